axis_pkt_fifo_mc: RTL and testbench

AXIS_PKT_FIFO_MC -- requirements
Module: axis_pkt_fifo_mc

---
 rtl/axis_pkt_fifo_pkg.sv | 12 +
 rtl/axis_pkt_fifo_chan.sv | 78 +++++++
 rtl/axis_pkt_fifo_mc.sv | 160 ++++++++++++++++
 tb/tb_axis_pkt_fifo_mc.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_fifo_pkg.sv
package axis_pkt_fifo_pkg;

  localparam int REG_CLEAR = 0;
  localparam int REG_SF    = 1;
  localparam int REG_SEL   = 2;

  typedef enum logic {
    ST_IDLE,
    ST_PASS
  } arb_state_t;

endpackage

// File: rtl/axis_pkt_fifo_chan.sv
module axis_pkt_fifo_chan
  import axis_pkt_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SIZE  = 9
) (
  input  logic             bus_clk,
  input  logic             bus_rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic             sf_en,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_tdata,
  output logic             rd_tlast,
  output logic             empty,
  output logic [31:0]      occupied,
  output logic [31:0]      pkt_count,
  output logic             eligible
);

  logic [WIDTH:0] mem [2**SIZE];
  logic [SIZE:0]  wr_ptr;
  logic [SIZE:0]  rd_ptr;
  logic [SIZE:0]  used;
  logic           full;
  logic           wr_en;
  logic           rd_ok;
  logic           inc;
  logic           dec;

  assign used     = wr_ptr - rd_ptr;
  assign full     = used[SIZE];
  assign empty    = (used == '0);
  assign occupied = 32'(used);

  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign i_tready = run && !clear && (!full || rd_en);
  assign wr_en    = i_tvalid && i_tready;
  assign rd_ok    = rd_en && !empty;

  assign {rd_tlast, rd_tdata} = mem[rd_ptr[SIZE-1:0]];

  assign inc = wr_en && i_tlast;
  assign dec = rd_ok && rd_tlast;

  // A full store-and-forward FIFO with no complete packet is flushed so an
  // oversize packet cannot wedge the channel.
  assign eligible = !clear && (sf_en ? ((pkt_count != '0) || full) : !empty);

  always_ff @(posedge bus_clk) begin
    if (wr_en) mem[wr_ptr[SIZE-1:0]] <= {i_tlast, i_tdata};
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({inc, dec})
        2'b10:   pkt_count <= pkt_count + 32'd1;
        2'b01:   pkt_count <= pkt_count - 32'd1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: rtl/axis_pkt_fifo_mc.sv
module axis_pkt_fifo_mc
  import axis_pkt_fifo_pkg::*;
#(
  parameter  int WIDTH    = 64,
  parameter  int SIZE     = 9,
  parameter  int NUM_CHAN = 2,
  parameter  int SR_BASE  = 0,
  localparam int DW       = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                      bus_clk,
  input  logic                      bus_rst_n,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  output logic [63:0]               rb_data,
  input  logic [NUM_CHAN*WIDTH-1:0] i_tdata,
  input  logic [NUM_CHAN-1:0]       i_tlast,
  input  logic [NUM_CHAN-1:0]       i_tvalid,
  output logic [NUM_CHAN-1:0]       i_tready,
  output logic [WIDTH-1:0]          o_tdata,
  output logic                      o_tlast,
  output logic                      o_tvalid,
  input  logic                      o_tready,
  output logic [DW-1:0]             o_tdest
);

  localparam logic [7:0] ADDR_CLEAR = 8'(SR_BASE + REG_CLEAR);
  localparam logic [7:0] ADDR_SF    = 8'(SR_BASE + REG_SF);
  localparam logic [7:0] ADDR_SEL   = 8'(SR_BASE + REG_SEL);

  logic [NUM_CHAN-1:0] clear_r;
  logic [NUM_CHAN-1:0] sf_r;
  logic [3:0]          sel_r;
  logic                run;
  logic [63:0]         rb_nxt;
  logic                unused_set;

  logic [NUM_CHAN-1:0] elig;
  logic [NUM_CHAN-1:0] empty;
  logic [NUM_CHAN-1:0] rd_en;
  logic [NUM_CHAN-1:0] head_last;
  logic [WIDTH-1:0]    head_data [NUM_CHAN];
  logic [31:0]         occ       [NUM_CHAN];
  logic [31:0]         pkt       [NUM_CHAN];

  arb_state_t    state, state_nxt;
  logic [DW-1:0] grant, grant_nxt, cand;
  logic          found;
  logic          g_clear, g_empty, g_last;
  logic [WIDTH-1:0] g_data;
  logic          pop;

  assign unused_set = ^set_data[31:4];

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      clear_r <= '0;
      sf_r    <= '0;
      sel_r   <= '0;
      run     <= 1'b0;
      rb_data <= '0;
    end else begin
      run     <= 1'b1;
      rb_data <= rb_nxt;
      if (set_stb) begin
        if (set_addr == ADDR_CLEAR) clear_r <= set_data[NUM_CHAN-1:0];
        if (set_addr == ADDR_SF)    sf_r    <= set_data[NUM_CHAN-1:0];
        if (set_addr == ADDR_SEL)   sel_r   <= set_data[3:0];
      end
    end
  end

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    axis_pkt_fifo_chan #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE)
    ) u_chan (
      .bus_clk   (bus_clk),
      .bus_rst_n (bus_rst_n),
      .run       (run),
      .clear     (clear_r[c]),
      .sf_en     (sf_r[c]),
      .i_tdata   (i_tdata[c*WIDTH +: WIDTH]),
      .i_tlast   (i_tlast[c]),
      .i_tvalid  (i_tvalid[c]),
      .i_tready  (i_tready[c]),
      .rd_en     (rd_en[c]),
      .rd_tdata  (head_data[c]),
      .rd_tlast  (head_last[c]),
      .empty     (empty[c]),
      .occupied  (occ[c]),
      .pkt_count (pkt[c]),
      .eligible  (elig[c])
    );
    assign rd_en[c] = pop && (grant == DW'(c));
  end

  always_comb begin
    g_clear = 1'b0;
    g_empty = 1'b1;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned c = 0; c < unsigned'(NUM_CHAN); c++) begin
      if (grant == DW'(c)) begin
        g_clear = clear_r[c];
        g_empty = empty[c];
        g_last  = head_last[c];
        g_data  = head_data[c];
      end
    end
  end

  always_comb begin
    rb_nxt = '0;
    for (int unsigned c = 0; c < unsigned'(NUM_CHAN); c++) begin
      if (sel_r == 4'(c)) rb_nxt = {pkt[c], occ[c]};
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state <= ST_IDLE;
      grant <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // grant doubles as the round-robin pointer: the search starts just past it.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cand      = '0;
    found     = 1'b0;
    case (state)
      ST_IDLE: begin
        for (int unsigned i = 1; i <= unsigned'(NUM_CHAN); i++) begin
          cand = DW'((32'(grant) + i) % unsigned'(NUM_CHAN));
          if (!found && elig[cand]) begin
            found     = 1'b1;
            grant_nxt = cand;
            state_nxt = ST_PASS;
          end
        end
      end
      ST_PASS: begin
        if (g_clear || (pop && g_last)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_tvalid = (state == ST_PASS) && !g_empty && !g_clear;
  assign pop      = o_tvalid && o_tready;
  assign o_tdata  = o_tvalid ? g_data : '0;
  assign o_tlast  = o_tvalid && g_last;
  assign o_tdest  = grant;

endmodule

// File: tb/tb_axis_pkt_fifo_mc.sv
module tb_axis_pkt_fifo_mc;
  import axis_pkt_fifo_pkg::*;

  logic clk;
  logic rst_n;
  logic a_stb, b_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  logic [63:0]  a_rb, b_rb;
  logic [127:0] a_idata, b_idata;
  logic [1:0]   a_ilast, a_ivld, a_irdy, b_ilast, b_ivld, b_irdy;
  logic [63:0]  a_odata, b_odata;
  logic         a_olast, a_ovld, a_ordy, b_olast, b_ovld, b_ordy;
  logic [0:0]   a_odest, b_odest;

  logic [63:0] a_d0, a_d1, b_d0, b_d1;
  logic        a_l0, a_l1, a_v0, a_v1, b_l0, b_l1, b_v0, b_v1;

  assign a_idata = {a_d1, a_d0};
  assign a_ilast = {a_l1, a_l0};
  assign a_ivld  = {a_v1, a_v0};
  assign b_idata = {b_d1, b_d0};
  assign b_ilast = {b_l1, b_l0};
  assign b_ivld  = {b_v1, b_v0};

  int errors = 0;
  int checks = 0;
  int a_mode = 0;
  bit a_seen = 0;
  int stab_err = 0;
  logic [65:0] q_a[$];
  logic [65:0] q_b[$];
  logic [65:0] prev_a;
  bit prev_stall = 0;

  axis_pkt_fifo_mc #(.WIDTH(64), .SIZE(9), .NUM_CHAN(2), .SR_BASE(0)) dut_a (
    .bus_clk(clk), .bus_rst_n(rst_n), .set_stb(a_stb), .set_addr(set_addr),
    .set_data(set_data), .rb_data(a_rb), .i_tdata(a_idata), .i_tlast(a_ilast),
    .i_tvalid(a_ivld), .i_tready(a_irdy), .o_tdata(a_odata), .o_tlast(a_olast),
    .o_tvalid(a_ovld), .o_tready(a_ordy), .o_tdest(a_odest)
  );

  axis_pkt_fifo_mc #(.WIDTH(64), .SIZE(4), .NUM_CHAN(2), .SR_BASE(0)) dut_b (
    .bus_clk(clk), .bus_rst_n(rst_n), .set_stb(b_stb), .set_addr(set_addr),
    .set_data(set_data), .rb_data(b_rb), .i_tdata(b_idata), .i_tlast(b_ilast),
    .i_tvalid(b_ivld), .i_tready(b_irdy), .o_tdata(b_odata), .o_tlast(b_olast),
    .o_tvalid(b_ovld), .o_tready(b_ordy), .o_tdest(b_odest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    a_ordy = 1'b1;
    b_ordy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (a_mode)
        0:       a_ordy = 1'b1;
        1:       a_ordy = 1'($urandom_range(0, 1));
        default: a_ordy = 1'b0;
      endcase
      b_ordy = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (a_ovld) a_seen = 1'b1;
      if (prev_stall && a_ovld && ({a_odest, a_olast, a_odata} !== prev_a)) stab_err++;
      prev_stall = a_ovld && !a_ordy;
      prev_a     = {a_odest, a_olast, a_odata};
      if (a_ovld && a_ordy) q_a.push_back({a_odest, a_olast, a_odata});
      if (b_ovld && b_ordy) q_b.push_back({b_odest, b_olast, b_odata});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] q_at(input bit dut, input int i);
    if (dut) return (i < q_b.size()) ? q_b[i] : '1;
    return (i < q_a.size()) ? q_a[i] : '1;
  endfunction

  task automatic set_in(input int dut, input int ch, input logic v, input logic [63:0] d,
                        input logic l);
    case ({dut[0], ch[0]})
      2'b00:   begin a_v0 = v; a_d0 = d; a_l0 = l; end
      2'b01:   begin a_v1 = v; a_d1 = d; a_l1 = l; end
      2'b10:   begin b_v0 = v; b_d0 = d; b_l0 = l; end
      default: begin b_v1 = v; b_d1 = d; b_l1 = l; end
    endcase
  endtask

  task automatic send_pkt(input int dut, input int ch, input logic [63:0] base, input int n,
                          input bit with_last);
    bit acc;
    for (int i = 0; i < n; i++) begin
      set_in(dut, ch, 1'b1, base + 64'(i), with_last && (i == n - 1));
      acc = 1'b0;
      for (int t = 0; t < 2000 && !acc; t++) begin
        @(negedge clk);
        acc = (dut == 0) ? a_irdy[ch] : b_irdy[ch];
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        check("tready_wait", 80'(acc), 80'd1);
        break;
      end
    end
    set_in(dut, ch, 1'b0, '0, 1'b0);
  endtask

  task automatic wr_reg(input bit dut, input int off, input logic [31:0] d);
    set_addr = 8'(off);
    set_data = d;
    if (dut) b_stb = 1'b1;
    else     a_stb = 1'b1;
    @(posedge clk);
    #1;
    a_stb = 1'b0;
    b_stb = 1'b0;
  endtask

  task automatic wait_q(input bit dut, input int n, input string tag);
    for (int t = 0; t < 5000; t++) begin
      if ((dut ? q_b.size() : q_a.size()) >= n) break;
      @(posedge clk);
      #1;
    end
    repeat (10) @(posedge clk);
    #1;
    check(tag, 80'(dut ? q_b.size() : q_a.size()), 80'(n));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    a_stb = 1'b0;
    b_stb = 1'b0;
    set_addr = '0;
    set_data = '0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) set_in(d, c, 1'b0, '0, 1'b0);
    cyc(3);
    check("rst_ovld", 80'(a_ovld), 80'd0);
    check("rst_odata", 80'({a_olast, a_odata}), 80'd0);
    check("rst_odest", 80'(a_odest), 80'd0);
    check("rst_rb", 80'(a_rb), 80'd0);
    check("rst_irdy", 80'(a_irdy), 80'd0);
    rst_n = 1'b1;
    cyc(3);
    check("irdy_up", 80'(a_irdy), 80'd3);

    // 16-beat ramp, cut-through ch0
    q_a.delete();
    send_pkt(0, 0, 64'h1000, 16, 1'b1);
    wait_q(0, 16, "t1_cnt");
    for (int i = 0; i < 16; i++)
      check("t1_beat", 80'(q_at(0, i)), 80'({1'b0, i == 15, 64'h1000 + 64'(i)}));

    // first-beat latency into an idle, empty cut-through channel
    q_a.delete();
    set_in(0, 0, 1'b1, 64'h1111, 1'b1);
    @(negedge clk);
    check("lat_rdy", 80'(a_irdy[0]), 80'd1);
    @(posedge clk);
    #1;
    set_in(0, 0, 1'b0, '0, 1'b0);
    lat = 99;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (a_ovld) begin
        lat = t;
        break;
      end
    end
    check("lat_le3", 80'(lat <= 3), 80'd1);
    wait_q(0, 1, "lat_cnt");
    check("lat_beat", 80'(q_at(0, 0)), 80'({1'b0, 1'b1, 64'h1111}));

    // store-and-forward ch1: nothing leaves until tlast is written
    wr_reg(0, REG_SF, 32'd2);
    wr_reg(0, REG_SEL, 32'd1);
    q_a.delete();
    a_seen = 1'b0;
    send_pkt(0, 1, 64'h2000, 19, 1'b0);
    cyc(10);
    check("t2_novld", 80'(a_seen), 80'd0);
    check("t2_rb_hold", 80'(a_rb), 80'({32'd0, 32'd19}));
    a_mode = 2;
    send_pkt(0, 1, 64'h2013, 1, 1'b1);
    cyc(4);
    check("t2_rb_pkt1", 80'(a_rb), 80'({32'd1, 32'd20}));
    check("t2_vld", 80'(a_ovld), 80'd1);
    a_mode = 0;
    wait_q(0, 20, "t2_cnt");
    for (int i = 0; i < 20; i++)
      check("t2_beat", 80'(q_at(0, i)), 80'({1'b1, i == 19, 64'h2000 + 64'(i)}));
    check("t2_rb_pkt0", 80'(a_rb), 80'd0);

    // two channels, 10 packets each, random backpressure; last grant was ch1
    wr_reg(0, REG_SF, 32'd0);
    q_a.delete();
    a_mode = 1;
    fork
      begin
        for (int p = 0; p < 10; p++) send_pkt(0, 0, 64'h3000_0000 + 64'(p * 256), 20, 1'b1);
      end
      begin
        for (int p = 0; p < 10; p++) send_pkt(0, 1, 64'h3001_0000 + 64'(p * 256), 20, 1'b1);
      end
    join
    wait_q(0, 400, "t3_cnt");
    a_mode = 0;
    for (int k = 0; k < 400; k++) begin
      int p, b, ch;
      p  = k / 20;
      b  = k % 20;
      ch = p % 2;
      check("t3_beat", 80'(q_at(0, k)),
            80'({1'(ch), b == 19, 64'h3000_0000 + 64'(ch * 65536) + 64'((p / 2) * 256) + 64'(b)}));
    end

    // SIZE=4 store-and-forward, 40-beat packet forces a flush
    wr_reg(1, REG_SF, 32'd1);
    q_b.delete();
    send_pkt(1, 0, 64'h4000, 40, 1'b1);
    wait_q(1, 40, "t4_cnt");
    for (int i = 0; i < 40; i++)
      check("t4_beat", 80'(q_at(1, i)), 80'({1'b0, i == 39, 64'h4000 + 64'(i)}));

    // clear ch0 while it holds the grant mid-packet
    q_a.delete();
    a_mode = 2;
    send_pkt(0, 0, 64'h5000, 8, 1'b0);
    wr_reg(0, REG_SEL, 32'd0);
    cyc(2);
    check("t5_vld_pre", 80'(a_ovld), 80'd1);
    check("t5_dest_pre", 80'(a_odest), 80'd0);
    check("t5_rb_pre", 80'(a_rb), 80'({32'd0, 32'd8}));
    wr_reg(0, REG_CLEAR, 32'd1);
    @(negedge clk);
    check("t5_vld_clr", 80'(a_ovld), 80'd0);
    cyc(2);
    check("t5_rb_clr", 80'(a_rb), 80'd0);
    wr_reg(0, REG_CLEAR, 32'd0);
    a_mode = 0;
    send_pkt(0, 1, 64'h5100, 12, 1'b1);
    wait_q(0, 12, "t5_cnt");
    for (int i = 0; i < 12; i++)
      check("t5_beat", 80'(q_at(0, i)), 80'({1'b1, i == 11, 64'h5100 + 64'(i)}));

    // reset pulsed mid-packet
    q_a.delete();
    a_mode = 2;
    send_pkt(0, 0, 64'h6000, 6, 1'b0);
    cyc(2);
    check("t6_vld_pre", 80'(a_ovld), 80'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_vld", 80'(a_ovld), 80'd0);
    check("t6_rst_data", 80'({a_olast, a_odata}), 80'd0);
    check("t6_rst_dest", 80'(a_odest), 80'd0);
    check("t6_rst_rb", 80'(a_rb), 80'd0);
    check("t6_rst_irdy", 80'(a_irdy), 80'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    a_mode = 0;
    send_pkt(0, 0, 64'h6100, 16, 1'b1);
    wait_q(0, 16, "t6_cnt");
    for (int i = 0; i < 16; i++)
      check("t6_beat", 80'(q_at(0, i)), 80'({1'b0, i == 15, 64'h6100 + 64'(i)}));

    check("stable", 80'(stab_err), 80'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
